// File: rtl/video_tpg_pkg.sv
// Shared definitions for the video test-pattern generator: pattern modes,
// colour-bar table and moving-bar geometry.
package video_tpg_pkg;

  typedef enum logic [2:0] {
    MODE_SOLID = 3'd0,
    MODE_BARS  = 3'd1,
    MODE_RAMP  = 3'd2,
    MODE_CHECK = 3'd3,
    MODE_MBAR  = 3'd4
  } mode_e;

  localparam int unsigned MBAR_W   = 16;
  localparam int unsigned NUM_BARS = 8;

  // {R,G,B} on/off per bar; index NUM_BARS and above is the black remainder
  function automatic logic [2:0] bar_rgb(input logic [3:0] idx);
    case (idx)
      4'd0:    return 3'b111;  // white
      4'd1:    return 3'b110;  // yellow
      4'd2:    return 3'b011;  // cyan
      4'd3:    return 3'b010;  // green
      4'd4:    return 3'b101;  // magenta
      4'd5:    return 3'b100;  // red
      4'd6:    return 3'b001;  // blue
      default: return 3'b000;  // black
    endcase
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster timing: h/v counters plus registered DE, HSYNC, VSYNC and
// frame_start, all one cycle behind the counter state.
module video_timing_counter
  import video_tpg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          en,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic          frame_first_o,
  output logic          line_last_o,
  output logic          de_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_start_o
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          de_q, hs_q, vs_q, fs_q;
  logic          line_last, frame_first, active, hs_on, vs_on;

  always_comb begin
    line_last   = (h_q == HW'(H_TOTAL - 1));
    frame_first = (h_q == '0) && (v_q == '0);
    active      = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs_on       = (32'(h_q) >= H_ACTIVE + H_FP) &&
                  (32'(h_q) <  H_ACTIVE + H_FP + H_SYNC);
    vs_on       = (32'(v_q) >= V_ACTIVE + V_FP) &&
                  (32'(v_q) <  V_ACTIVE + V_FP + V_SYNC);
    h_d = h_q;
    v_d = v_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else if (line_last) begin
      h_d = '0;
      v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      h_q  <= '0;
      v_q  <= '0;
      de_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      de_q <= en && active;
      hs_q <= (en && hs_on) ? HS_POL : ~HS_POL;
      vs_q <= (en && vs_on) ? VS_POL : ~VS_POL;
      fs_q <= en && frame_first;
    end
  end

  assign h_cnt_o       = h_q;
  assign v_cnt_o       = v_q;
  assign frame_first_o = frame_first;
  assign line_last_o   = line_last;
  assign de_o          = de_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/video_tpg.sv
// Video test-pattern generator: raster timing, frame-synchronous pattern
// selection and registered RGB/DE/sync outputs.
module video_tpg
  import video_tpg_pkg::*;
#(
  parameter int unsigned BPC      = 8,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CHK_LOG2 = 5,
  parameter int unsigned BAR_STEP = 4
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [3*BPC-1:0]   solid_color,
  output logic [3*BPC-1:0]   vid_data,
  output logic               vid_de,
  output logic               vid_hsync,
  output logic               vid_vsync,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = 3 * BPC;
  localparam int unsigned BAR_W   = H_ACTIVE / NUM_BARS;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          frame_first, line_last;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL)
  ) u_timing (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .en            (en),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .frame_first_o (frame_first),
    .line_last_o   (line_last),
    .de_o          (vid_de),
    .hsync_o       (vid_hsync),
    .vsync_o       (vid_vsync),
    .frame_start_o (frame_start)
  );

  logic [2:0]    mode_q;
  logic [DW-1:0] color_q;
  logic [HW-1:0] bar_x_q, bar_x_d;
  logic [HW-1:0] bar_pix_q, bar_pix_d;
  logic [3:0]    bar_idx_q, bar_idx_d;
  logic [DW-1:0] data_q, data_d;

  logic [2:0]    eff_mode;
  logic [DW-1:0] eff_color, pix;
  logic [31:0]   h32, v32, bx32;
  logic [2:0]    rgb;
  logic          active, frame_last;

  // At h=0,v=0 the live inputs drive the pixel so that a change in that very
  // cycle already applies; the shadow copy covers the rest of the frame.
  always_comb begin
    h32        = 32'(h_cnt);
    v32        = 32'(v_cnt);
    bx32       = 32'(bar_x_q);
    active     = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    frame_last = line_last && (v32 == V_TOTAL - 1);
    eff_mode   = frame_first ? mode : mode_q;
    eff_color  = frame_first ? solid_color : color_q;
    rgb        = bar_rgb(bar_idx_q);
    pix        = '0;
    case (eff_mode)
      MODE_SOLID: pix = eff_color;
      MODE_BARS:  pix = {{BPC{rgb[2]}}, {BPC{rgb[1]}}, {BPC{rgb[0]}}};
      MODE_RAMP:  pix = {3{h32[BPC-1:0]}};
      MODE_CHECK: pix = (h32[CHK_LOG2] ^ v32[CHK_LOG2]) ? '1 : '0;
      MODE_MBAR:  pix = (h32 >= bx32 && h32 < bx32 + MBAR_W) ? '1 : eff_color;
      default:    pix = '0;
    endcase
    data_d = (en && active) ? pix : '0;
  end

  // Bar counters track h_cnt in lockstep; the index saturates past the last
  // bar so remainder pixels fall through to black.
  always_comb begin
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    if (!en || line_last) begin
      bar_pix_d = '0;
      bar_idx_d = '0;
    end else if (bar_idx_q < 4'(NUM_BARS)) begin
      if (bar_pix_q == HW'(BAR_W - 1)) begin
        bar_pix_d = '0;
        bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_pix_d = bar_pix_q + 1'b1;
      end
    end
  end

  always_comb begin
    bar_x_d = bar_x_q;
    if (en && frame_last) begin
      bar_x_d = HW'((bx32 + BAR_STEP) % H_ACTIVE);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mode_q    <= '0;
      color_q   <= '0;
      bar_x_q   <= '0;
      bar_pix_q <= '0;
      bar_idx_q <= '0;
      data_q    <= '0;
    end else begin
      if (en && frame_first) begin
        mode_q  <= mode;
        color_q <= solid_color;
      end
      bar_x_q   <= bar_x_d;
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      data_q    <= data_d;
    end
  end

  assign vid_data = data_q;

endmodule
